fetch_decode_execute: RTL and testbench
=======================================

FETCH_DECODE_EXECUTE -- requirements
Module: fetch_decode_execute

Interface
REQ-001 Parameter WORD, default 64: datapath, register and PC width.
REQ-002 Parameter INSTR_LEN, default 32: instruction width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instruction  input  32  instruction word fetched at address pc.
REQ-006 pc_src  input  1  1 = take branch_target at next edge; supplied by the downstream branch decision.
REQ-007 write_data  input  64  writeback value for register Rd.
REQ-008 pc  output  64  current instruction address.
REQ-009 opcode  output  11  instruction[31:21].
REQ-010 read_data1, read_data2  output  64 each  register operands; read_data2 is also the store data.
REQ-011 alu_result  output  64  ALU result / memory address.
REQ-012 branch_target  output  64  pc + (extended_instruction << 2).
REQ-013 zero, negative, carry, overflow  output  1 each  ALU flags of the current instruction.
REQ-014 sreg  output  32  status register; bits [3:0] = {N,Z,C,V}; bits [31:4] = 0.
REQ-015 mem_read, mem_write, mem_to_reg, reg_write  output  1 each  control signals.
REQ-016 branch_op  output  3  branch class: 000 none, 001 B, 010 CBZ, 011 CBNZ, 100 B.cond.

Function
REQ-017 Fetch: each rising edge, pc SHALL load branch_target if pc_src = 1, otherwise pc + 4 (mod 2^64).
REQ-018 Decode and execute paths SHALL be combinational from instruction and register contents; results are valid within the same cycle.
REQ-019 Register file: 32 x 64 bits; X31 SHALL always read 0 and ignore writes.
REQ-020 Register reads SHALL be combinational.
REQ-021 Register write: on the rising edge, Rd = instruction[4:0] is written with write_data when reg_write = 1.
REQ-022 Read-during-write SHALL return the old register value.
REQ-023 Register read ports: Rn = instruction[9:5]; second port = Rm [20:16] for R-format, else Rt [4:0] (STUR, CBZ, CBNZ).
REQ-024 Immediates:
- I-format: zero-extend [21:10].
- D-format: sign-extend [20:12].
- B: sign-extend [25:0].
- CB: sign-extend [23:5].
- Otherwise 0.
REQ-025 Supported opcodes and ALU operations:
- ADD/ADDS 10001011000/10101011000
- SUB/SUBS 11001011000/11101011000
- AND/ANDS 10001010000/11101010000
- ORR 10101010000
- EOR 11001010000
- LSL/LSR 11010011011/11010011010: shift by shamt [15:10]
- ADDI/ADDIS, SUBI/SUBIS, ANDI, ORRI: 10-bit opcodes 1001000100/1011000100, 1101000100/1111000100, 1001001000, 1011001000
- LDUR 11111000010, STUR 11111000000: alu_result = Rn + imm
- B 000101
- CBZ 10110100, CBNZ 10110101: ALU passes read_data2
- B.cond 01010100
REQ-026 Control signals:
- reg_write = 1 for ALU ops and LDUR.
- mem_read = mem_to_reg = 1 for LDUR only.
- mem_write = 1 for STUR only.
REQ-027 Unrecognised opcodes SHALL act as NOPs: all controls 0, branch_op = 000, no flag update.
REQ-028 Flags:
- zero = (alu_result == 0); negative = alu_result[63].
- carry = carry-out for add; NOT borrow for subtract.
- overflow = signed overflow for add/sub.
- carry = overflow = 0 for logic and shift operations.
REQ-029 sreg SHALL load {N,Z,C,V} at the rising edge only for flag-setting ops (ADDS, SUBS, ANDS, ADDIS, SUBIS); otherwise it holds.

Reset
REQ-030 While reset = 0: pc = 0, sreg = 0, and all registers = 0, asynchronously.
REQ-031 Reset asserted mid-cycle SHALL override any pending write or branch.
REQ-032 The first fetch after deassertion SHALL be at address 0.

Structure
REQ-033 A shared package SHALL hold WORD, INSTR_LEN, the opcode constants, the branch_op encodings and the ALU-operation enum.
REQ-034 One sub-module, regfile (32x64, async reset, X31 hardwired to zero), SHALL be instantiated; fetch, decode and ALU logic stay in the top.

Verification
REQ-035 Reset released, pc_src = 0, NOP instruction: pc = 0, 4, 8 on successive edges.
REQ-036 ADDI X1,X31,#5 (0x910017E1) with write_data = 5: alu_result = 5, reg_write = 1; a following ADD X2,X1,X1 yields alu_result = 10.
REQ-037 SUBS X3,X1,X1 with X1 = 5: alu_result = 0, zero = 1, carry = 1, overflow = 0; sreg = 0x6 after the edge.
REQ-038 B #-2 at pc = 8 with pc_src = 1: branch_target = 0, branch_op = 001, next pc = 0.
REQ-039 STUR X1,[X31,#8]: mem_write = 1, reg_write = 0, alu_result = 8, read_data2 = X1; LDUR sets mem_read = mem_to_reg = 1.
REQ-040 Assert reset at pc = 0x20 between edges: pc = 0 and sreg = 0 immediately; X1 reads 0.

Source files
------------

// File: rtl/fetch_decode_execute_pkg.sv
// rtl/fetch_decode_execute_pkg.sv - shared widths, opcode constants, branch classes and ALU operations
package fetch_decode_execute_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    // 11-bit R-format and D-format opcodes, instruction[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // 10-bit I-format opcodes, instruction[31:22]
    localparam logic [9:0] OP_ADDI  = 10'b1001000100;
    localparam logic [9:0] OP_ADDIS = 10'b1011000100;
    localparam logic [9:0] OP_SUBI  = 10'b1101000100;
    localparam logic [9:0] OP_SUBIS = 10'b1111000100;
    localparam logic [9:0] OP_ANDI  = 10'b1001001000;
    localparam logic [9:0] OP_ORRI  = 10'b1011001000;

    // 8-bit CB-format opcodes, instruction[31:24]; 6-bit B opcode, instruction[31:26]
    localparam logic [7:0] OP_CBZ   = 8'b10110100;
    localparam logic [7:0] OP_CBNZ  = 8'b10110101;
    localparam logic [7:0] OP_BCOND = 8'b01010100;
    localparam logic [5:0] OP_B     = 6'b000101;

    localparam logic [2:0] BR_NONE  = 3'b000;
    localparam logic [2:0] BR_B     = 3'b001;
    localparam logic [2:0] BR_CBZ   = 3'b010;
    localparam logic [2:0] BR_CBNZ  = 3'b011;
    localparam logic [2:0] BR_BCOND = 3'b100;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_EOR,
        ALU_LSL,
        ALU_LSR,
        ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_D,
        IMM_B,
        IMM_CB
    } imm_sel_e;

endpackage

// File: rtl/fetch_decode_execute_regfile.sv
// rtl/fetch_decode_execute_regfile.sv - 32 x WORD register file, combinational reads, X31 reads as zero
module fetch_decode_execute_regfile #(
    parameter int WORD = fetch_decode_execute_pkg::WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      read_addr1,
    input  logic [4:0]      read_addr2,
    output logic [WORD-1:0] read_data1,
    output logic [WORD-1:0] read_data2,
    input  logic            write_en,
    input  logic [4:0]      write_addr,
    input  logic [WORD-1:0] write_data
);

    logic [WORD-1:0] regs [32];

    // Entry 31 is never written, so it stays at its reset value; the read mux makes zero explicit anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (write_addr != 5'd31)) begin
            regs[write_addr] <= write_data;
        end
    end

    assign read_data1 = (read_addr1 == 5'd31) ? '0 : regs[read_addr1];
    assign read_data2 = (read_addr2 == 5'd31) ? '0 : regs[read_addr2];

endmodule

// File: rtl/fetch_decode_execute.sv
// rtl/fetch_decode_execute.sv - single-cycle fetch, decode and execute for a LEGv8 subset
module fetch_decode_execute #(
    parameter int WORD      = fetch_decode_execute_pkg::WORD,
    parameter int INSTR_LEN = fetch_decode_execute_pkg::INSTR_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic                 pc_src,
    input  logic [WORD-1:0]      write_data,
    output logic [WORD-1:0]      pc,
    output logic [10:0]          opcode,
    output logic [WORD-1:0]      read_data1,
    output logic [WORD-1:0]      read_data2,
    output logic [WORD-1:0]      alu_result,
    output logic [WORD-1:0]      branch_target,
    output logic                 zero,
    output logic                 negative,
    output logic                 carry,
    output logic                 overflow,
    output logic [31:0]          sreg,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic [2:0]           branch_op
);

    import fetch_decode_execute_pkg::*;

    alu_op_e         alu_op;
    imm_sel_e        imm_sel;
    logic            alu_src;
    logic            use_rm;
    logic            set_flags;
    logic [4:0]      read_addr2;
    logic [WORD-1:0] imm;
    logic [WORD-1:0] alu_b;
    logic [WORD:0]   sum;
    logic [WORD:0]   diff;

    assign opcode = instruction[31:21];

    // Decode: longest opcode field first, so 11-bit formats win over shorter prefixes.
    always_comb begin
        alu_op     = ALU_NONE;
        imm_sel    = IMM_NONE;
        alu_src    = 1'b0;
        use_rm     = 1'b0;
        set_flags  = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch_op  = BR_NONE;
        case (opcode)
            OP_ADD, OP_ADDS: begin
                alu_op = ALU_ADD; use_rm = 1'b1; reg_write = 1'b1; set_flags = (opcode == OP_ADDS);
            end
            OP_SUB, OP_SUBS: begin
                alu_op = ALU_SUB; use_rm = 1'b1; reg_write = 1'b1; set_flags = (opcode == OP_SUBS);
            end
            OP_AND, OP_ANDS: begin
                alu_op = ALU_AND; use_rm = 1'b1; reg_write = 1'b1; set_flags = (opcode == OP_ANDS);
            end
            OP_ORR: begin alu_op = ALU_ORR; use_rm = 1'b1; reg_write = 1'b1; end
            OP_EOR: begin alu_op = ALU_EOR; use_rm = 1'b1; reg_write = 1'b1; end
            OP_LSL: begin alu_op = ALU_LSL; use_rm = 1'b1; reg_write = 1'b1; end
            OP_LSR: begin alu_op = ALU_LSR; use_rm = 1'b1; reg_write = 1'b1; end
            OP_LDUR: begin
                alu_op = ALU_ADD; imm_sel = IMM_D; alu_src = 1'b1;
                reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
            end
            OP_STUR: begin
                alu_op = ALU_ADD; imm_sel = IMM_D; alu_src = 1'b1; mem_write = 1'b1;
            end
            default: begin
                case (instruction[31:22])
                    OP_ADDI, OP_ADDIS: begin
                        alu_op = ALU_ADD; imm_sel = IMM_I; alu_src = 1'b1; reg_write = 1'b1;
                        set_flags = (instruction[31:22] == OP_ADDIS);
                    end
                    OP_SUBI, OP_SUBIS: begin
                        alu_op = ALU_SUB; imm_sel = IMM_I; alu_src = 1'b1; reg_write = 1'b1;
                        set_flags = (instruction[31:22] == OP_SUBIS);
                    end
                    OP_ANDI: begin alu_op = ALU_AND; imm_sel = IMM_I; alu_src = 1'b1; reg_write = 1'b1; end
                    OP_ORRI: begin alu_op = ALU_ORR; imm_sel = IMM_I; alu_src = 1'b1; reg_write = 1'b1; end
                    default: begin
                        case (instruction[31:24])
                            OP_CBZ:   begin alu_op = ALU_PASSB; imm_sel = IMM_CB; branch_op = BR_CBZ;  end
                            OP_CBNZ:  begin alu_op = ALU_PASSB; imm_sel = IMM_CB; branch_op = BR_CBNZ; end
                            OP_BCOND: begin imm_sel = IMM_CB; branch_op = BR_BCOND; end
                            default: begin
                                if (instruction[31:26] == OP_B) begin
                                    imm_sel   = IMM_B;
                                    branch_op = BR_B;
                                end
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I:   imm = {{(WORD-12){1'b0}}, instruction[21:10]};
            IMM_D:   imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
            IMM_B:   imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
            IMM_CB:  imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
            default: imm = '0;
        endcase
    end

    assign read_addr2 = use_rm ? instruction[20:16] : instruction[4:0];

    fetch_decode_execute_regfile #(.WORD(WORD)) regfile (
        .clk        (clk),
        .reset      (reset),
        .read_addr1 (instruction[9:5]),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .write_en   (reg_write),
        .write_addr (instruction[4:0]),
        .write_data (write_data)
    );

    assign branch_target = pc + (imm << 2);

    // Subtract as a + ~b + 1 so the carry-out is directly NOT borrow.
    assign alu_b = alu_src ? imm : read_data2;
    assign sum   = {1'b0, read_data1} + {1'b0, alu_b};
    assign diff  = {1'b0, read_data1} + {1'b0, ~alu_b} + (WORD+1)'(1);

    always_comb begin
        alu_result = '0;
        carry      = 1'b0;
        overflow   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_result = sum[WORD-1:0];
                carry      = sum[WORD];
                overflow   = (read_data1[WORD-1] == alu_b[WORD-1]) && (sum[WORD-1] != read_data1[WORD-1]);
            end
            ALU_SUB: begin
                alu_result = diff[WORD-1:0];
                carry      = diff[WORD];
                overflow   = (read_data1[WORD-1] != alu_b[WORD-1]) && (diff[WORD-1] != read_data1[WORD-1]);
            end
            ALU_AND:   alu_result = read_data1 & alu_b;
            ALU_ORR:   alu_result = read_data1 | alu_b;
            ALU_EOR:   alu_result = read_data1 ^ alu_b;
            ALU_LSL:   alu_result = read_data1 << instruction[15:10];
            ALU_LSR:   alu_result = read_data1 >> instruction[15:10];
            ALU_PASSB: alu_result = read_data2;
            default:   alu_result = '0;
        endcase
    end

    assign zero     = (alu_result == '0);
    assign negative = alu_result[WORD-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc   <= '0;
            sreg <= '0;
        end else begin
            pc <= pc_src ? branch_target : pc + WORD'(4);
            if (set_flags) begin
                sreg <= {28'd0, negative, zero, carry, overflow};
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// tb/tb_fetch_decode_execute.sv - scoreboard bench with a behavioural reference model for fetch_decode_execute
module tb_fetch_decode_execute;

    localparam logic [10:0] O_ADD  = 11'b10001011000, O_ADDS = 11'b10101011000;
    localparam logic [10:0] O_SUB  = 11'b11001011000, O_SUBS = 11'b11101011000;
    localparam logic [10:0] O_AND  = 11'b10001010000, O_ANDS = 11'b11101010000;
    localparam logic [10:0] O_ORR  = 11'b10101010000, O_EOR  = 11'b11001010000;
    localparam logic [10:0] O_LSL  = 11'b11010011011, O_LSR  = 11'b11010011010;
    localparam logic [10:0] O_LDUR = 11'b11111000010, O_STUR = 11'b11111000000;
    localparam logic [9:0]  O_ADDI = 10'b1001000100,  O_ADDIS = 10'b1011000100;
    localparam logic [9:0]  O_SUBI = 10'b1101000100,  O_SUBIS = 10'b1111000100;
    localparam logic [9:0]  O_ANDI = 10'b1001001000,  O_ORRI  = 10'b1011001000;
    localparam logic [7:0]  O_CBZ  = 8'b10110100, O_CBNZ = 8'b10110101, O_BCOND = 8'b01010100;
    localparam logic [5:0]  O_B    = 6'b000101;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        pc_src;
    logic [63:0] write_data;
    logic [63:0] pc, read_data1, read_data2, alu_result, branch_target;
    logic [10:0] opcode;
    logic        zero, negative, carry, overflow;
    logic [31:0] sreg;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic [2:0]  branch_op;

    fetch_decode_execute dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .pc_src        (pc_src),
        .write_data    (write_data),
        .pc            (pc),
        .opcode        (opcode),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .alu_result    (alu_result),
        .branch_target (branch_target),
        .zero          (zero),
        .negative      (negative),
        .carry         (carry),
        .overflow      (overflow),
        .sreg          (sreg),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .branch_op     (branch_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc, rd1, rd2, alu, bt;
        logic [10:0] opc;
        logic [31:0] sreg;
        logic [4:0]  rd;
        logic [2:0]  bop;
        logic        z, n, c, v, known, sf, rw, mr, mw, m2r;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    logic [63:0] mregs [32];
    logic [63:0] mpc;
    logic [31:0] msreg;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        mpc   = 64'd0;
        msreg = 32'd0;
    endtask

    // Architectural behaviour computed straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t                e;
        logic [63:0]         a, b, rm, rt, imm, r;
        logic [64:0]         w;
        logic signed [64:0]  sv;
        logic [10:0]         op11;
        logic [9:0]          op10;
        int                  mode;
        op11 = ins[31:21];
        op10 = ins[31:22];
        a  = mregs[ins[9:5]];
        rm = mregs[ins[20:16]];
        rt = mregs[ins[4:0]];
        e = '0;
        e.pc = mpc; e.opc = op11; e.sreg = msreg; e.rd1 = a; e.rd2 = rt; e.rd = ins[4:0];
        mode = 0; b = 64'd0; r = 64'd0; imm = 64'd0;
        if (op11 inside {O_ADD, O_ADDS, O_SUB, O_SUBS, O_AND, O_ANDS, O_ORR, O_EOR, O_LSL, O_LSR}) begin
            e.rd2 = rm; e.rw = 1'b1; b = rm;
            e.sf = (op11 == O_ADDS) || (op11 == O_SUBS) || (op11 == O_ANDS);
            if (op11 == O_ADD || op11 == O_ADDS)      mode = 1;
            else if (op11 == O_SUB || op11 == O_SUBS) mode = 2;
            else begin
                mode = 3;
                if (op11 == O_AND || op11 == O_ANDS) r = a & rm;
                else if (op11 == O_ORR)              r = a | rm;
                else if (op11 == O_EOR)              r = a ^ rm;
                else if (op11 == O_LSL)              r = a << ins[15:10];
                else                                 r = a >> ins[15:10];
            end
        end else if (op11 == O_LDUR || op11 == O_STUR) begin
            imm = 64'(ins[20:12]);
            if (ins[20]) imm -= 64'd512;
            mode = 1; b = imm;
            if (op11 == O_LDUR) begin e.rw = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; end
            else e.mw = 1'b1;
        end else if (op10 inside {O_ADDI, O_ADDIS, O_SUBI, O_SUBIS, O_ANDI, O_ORRI}) begin
            imm = 64'(ins[21:10]);
            b = imm; e.rw = 1'b1;
            e.sf = (op10 == O_ADDIS) || (op10 == O_SUBIS);
            if (op10 == O_ADDI || op10 == O_ADDIS)      mode = 1;
            else if (op10 == O_SUBI || op10 == O_SUBIS) mode = 2;
            else begin
                mode = 3;
                r = (op10 == O_ANDI) ? (a & imm) : (a | imm);
            end
        end else if (ins[31:24] == O_CBZ || ins[31:24] == O_CBNZ || ins[31:24] == O_BCOND) begin
            imm = 64'(ins[23:5]);
            if (ins[23]) imm -= 64'h80000;
            if (ins[31:24] == O_BCOND) e.bop = 3'd4;
            else begin
                mode = 3; r = rt;
                e.bop = (ins[31:24] == O_CBZ) ? 3'd2 : 3'd3;
            end
        end else if (ins[31:26] == O_B) begin
            imm = 64'(ins[25:0]);
            if (ins[25]) imm -= 64'h4000000;
            e.bop = 3'd1;
        end
        if (mode == 1) begin
            w  = {1'b0, a} + {1'b0, b};
            r  = w[63:0];
            e.c = w[64];
            sv = $signed({a[63], a}) + $signed({b[63], b});
            e.v = (sv > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (sv < -65'sh0_8000_0000_0000_0000);
        end else if (mode == 2) begin
            r  = a - b;
            e.c = (a >= b);
            sv = $signed({a[63], a}) - $signed({b[63], b});
            e.v = (sv > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (sv < -65'sh0_8000_0000_0000_0000);
        end
        if (mode != 0) begin
            e.known = 1'b1;
            e.alu = r;
            e.z = (r == 64'd0);
            e.n = r[63];
        end
        e.bt = mpc + imm * 64'd4;
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic ps, input logic [63:0] wd);
        exp_t e;
        instruction = ins;
        pc_src      = ps;
        write_data  = wd;
        e = model(ins);
        sb.push_back(e);
        @(posedge clk);
        if (e.rw && e.rd != 5'd31) mregs[e.rd] = wd;
        mpc = ps ? e.bt : mpc + 64'd4;
        if (e.sf) msreg = {28'd0, e.n, e.z, e.c, e.v};
        #1;
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [10:0] ops11 [12];
        logic [9:0]  ops10 [6];
        logic [31:0] r;
        int          k;
        ops11 = '{O_ADD, O_ADDS, O_SUB, O_SUBS, O_AND, O_ANDS, O_ORR, O_EOR, O_LSL, O_LSR, O_LDUR, O_STUR};
        ops10 = '{O_ADDI, O_ADDIS, O_SUBI, O_SUBIS, O_ANDI, O_ORRI};
        r = $urandom;
        k = $urandom_range(0, 23);
        if (k < 22) begin
            r[4:0] = rand_reg();
            r[9:5] = rand_reg();
        end
        if (k < 12) begin
            r[31:21] = ops11[k];
            if (k < 10) r[20:16] = rand_reg();
        end
        else if (k < 18) r[31:22] = ops10[k-12];
        else if (k == 18) r[31:24] = O_CBZ;
        else if (k == 19) r[31:24] = O_CBNZ;
        else if (k == 20) r[31:24] = O_BCOND;
        else if (k == 21) r[31:26] = O_B;
        return r;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("pc", pc, me.pc);
            chk("opcode", 64'(opcode), 64'(me.opc));
            chk("read_data1", read_data1, me.rd1);
            chk("read_data2", read_data2, me.rd2);
            chk("branch_target", branch_target, me.bt);
            chk("sreg", 64'(sreg), 64'(me.sreg));
            chk("ctrl", {60'd0, reg_write, mem_read, mem_write, mem_to_reg},
                {60'd0, me.rw, me.mr, me.mw, me.m2r});
            chk("branch_op", 64'(branch_op), 64'(me.bop));
            if (me.known) begin
                chk("alu_result", alu_result, me.alu);
                chk("flags", {60'd0, negative, zero, carry, overflow}, {60'd0, me.n, me.z, me.c, me.v});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        instruction = 32'h0000_0020;
        pc_src = 1'b0;
        write_data = 64'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, 64'd0);
        chk("reset_sreg", 64'(sreg), 64'd0);
        chk("reset_x1", read_data1, 64'd0);
        reset = 1'b1;

        step(32'h0000_0000, 1'b0, 64'd0);
        step(32'h0000_0000, 1'b0, 64'd0);
        step(32'h17FF_FFFE, 1'b1, 64'd0);
        step(32'h9100_17E1, 1'b0, 64'd5);
        step(32'h8B01_0022, 1'b0, 64'd10);
        step(32'hEB01_0023, 1'b0, 64'd0);
        step(32'hF800_83E1, 1'b0, 64'hDEAD_BEEF);
        step(32'hF840_83E4, 1'b0, 64'd5);
        step(32'h0000_0000, 1'b0, 64'd0);

        for (int i = 0; i < 400; i++) begin
            step(rand_instr(), ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        end

        // Mid-cycle reset, then rebuild state and drive pc to 0x20 with X1 = 5 and sreg = 6.
        reset = 1'b0;
        model_reset();
        #1;
        chk("midreset_pc", pc, 64'd0);
        reset = 1'b1;
        step(32'h9100_17E1, 1'b0, 64'd5);
        step(32'hEB01_0023, 1'b0, 64'd7);
        for (int i = 0; i < 6; i++) step(32'h0000_0000, 1'b0, 64'd0);
        instruction = 32'h9100_1421;
        pc_src      = 1'b1;
        write_data  = 64'h1234;
        #1;
        chk("pre_pc", pc, 64'h20);
        chk("pre_sreg", 64'(sreg), 64'h6);
        chk("pre_x1", read_data1, 64'd5);
        reset = 1'b0;
        #1;
        chk("async_pc", pc, 64'd0);
        chk("async_sreg", 64'(sreg), 64'd0);
        chk("async_x1", read_data1, 64'd0);
        @(posedge clk);
        #1;
        chk("held_pc", pc, 64'd0);
        chk("held_x1", read_data1, 64'd0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
